// File: rtl/fi_ctrl_pkg.sv
// rtl/fi_ctrl_pkg.sv - state encoding and fault-type codes shared by the fault injection controller
package fi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT,
    ST_INJECT,
    ST_DONE
  } fi_state_e;

  localparam logic [1:0] FT_SA0  = 2'b00;
  localparam logic [1:0] FT_SA1  = 2'b01;
  localparam logic [1:0] FT_FLIP = 2'b10;

endpackage

// File: rtl/fi_cycle_cnt.sv
// rtl/fi_cycle_cnt.sv - loadable down-counter timing the start delay and injection window
module fi_cycle_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins over dec; dec stops at zero so the count never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fault_injection_ctrl.sv
// rtl/fault_injection_ctrl.sv - campaign sequencer driving one saboteur enable for a timed window
module fault_injection_ctrl
  import fi_ctrl_pkg::*;
#(
  parameter int N_SBTR = 16,
  parameter int CNT_W  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_valid,
  output logic                      o_cfg_ready,
  input  logic [$clog2(N_SBTR)-1:0] i_cfg_target,
  input  logic [1:0]                i_cfg_type,
  input  logic [CNT_W-1:0]          i_cfg_start,
  input  logic [CNT_W-1:0]          i_cfg_dur,
  input  logic                      i_trig,
  input  logic                      i_abort,
  output logic [N_SBTR-1:0]         o_sbtr_en,
  output logic [1:0]                o_sbtr_ctrl,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int TGT_W = $clog2(N_SBTR);
  localparam logic [TGT_W:0] TGT_LIM = (TGT_W + 1)'(N_SBTR);

  fi_state_e          state_q, state_d;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic [1:0]         type_q, type_d;
  logic [CNT_W-1:0]   start_q, start_d;
  logic [CNT_W-1:0]   dur_q, dur_d;
  logic [N_SBTR-1:0]  en_q, en_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic               cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]   cnt_value;

  fi_cycle_cnt #(.W(CNT_W)) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .load    (cnt_load),
    .value   (cnt_value),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    type_d    = type_q;
    start_d   = start_q;
    dur_d     = dur_q;
    err_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_cfg_valid && ready_q) begin
          if ({1'b0, i_cfg_target} >= TGT_LIM) begin
            err_d = 1'b1;
          end else begin
            tgt_d   = i_cfg_target;
            type_d  = i_cfg_type;
            start_d = i_cfg_start;
            dur_d   = i_cfg_dur;
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (i_trig) begin
          cnt_load  = 1'b1;
          cnt_value = start_q;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          // the entry cycle is the first of the window, so count dur-1 more
          cnt_load  = 1'b1;
          cnt_value = (dur_q == '0) ? '0 : dur_q - CNT_W'(1);
          state_d   = ST_INJECT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_INJECT: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (dur_q != '0) begin
          if (cnt_zero) begin
            state_d = ST_DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // outputs follow the next state so every port comes straight from a flop
    en_d   = '0;
    ctrl_d = FT_SA0;
    if (state_d == ST_INJECT) begin
      en_d[tgt_d] = 1'b1;
      ctrl_d      = type_d;
    end
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      type_q  <= FT_SA0;
      start_q <= '0;
      dur_q   <= '0;
      en_q    <= '0;
      ctrl_q  <= FT_SA0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      type_q  <= type_d;
      start_q <= start_d;
      dur_q   <= dur_d;
      en_q    <= en_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign o_sbtr_en   = en_q;
  assign o_sbtr_ctrl = ctrl_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_cfg_ready = ready_q;

endmodule

// File: tb/tb_fault_injection_ctrl.sv
// tb/tb_fault_injection_ctrl.sv - scoreboard bench for the fault injection controller
module tb_fault_injection_ctrl;

  typedef struct packed {
    logic [15:0] en;
    logic [1:0]  ctrl;
    logic        busy;
    logic        done;
    logic        ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        cfg_valid, cfg_ready;
  logic [3:0]  cfg_target;
  logic [1:0]  cfg_type;
  logic [31:0] cfg_start, cfg_dur;
  logic        trig, abort_i;
  logic [15:0] sbtr_en;
  logic [1:0]  sbtr_ctrl;
  logic        busy, done, err;

  logic        e_valid, e_ready;
  logic [3:0]  e_target;
  logic [1:0]  e_type;
  logic [3:0]  e_start, e_dur;
  logic        e_trig, e_abort;
  logic [11:0] e_en;
  logic [1:0]  e_ctrl;
  logic        e_busy, e_done, e_err;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fault_injection_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_target (cfg_target),
    .i_cfg_type   (cfg_type),
    .i_cfg_start  (cfg_start),
    .i_cfg_dur    (cfg_dur),
    .i_trig       (trig),
    .i_abort      (abort_i),
    .o_sbtr_en    (sbtr_en),
    .o_sbtr_ctrl  (sbtr_ctrl),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  // narrow instance: non-power-of-two saboteur count and 4-bit counters
  fault_injection_ctrl #(.N_SBTR(12), .CNT_W(4)) dut_e (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (e_valid),
    .o_cfg_ready  (e_ready),
    .i_cfg_target (e_target),
    .i_cfg_type   (e_type),
    .i_cfg_start  (e_start),
    .i_cfg_dur    (e_dur),
    .i_trig       (e_trig),
    .i_abort      (e_abort),
    .o_sbtr_en    (e_en),
    .o_sbtr_ctrl  (e_ctrl),
    .o_busy       (e_busy),
    .o_done       (e_done),
    .o_err        (e_err)
  );

  // k counts output samples after the trigger edge; window is k = s+1 .. s+d
  task automatic push_campaign(input int tgt, input logic [1:0] ty, input int s,
                               input int d, input int n);
    exp_t e;
    bit   inj;
    for (int k = 0; k < n; k++) begin
      inj     = (k >= s + 1) && ((d == 0) || (k <= s + d));
      e.en    = inj ? (16'(1) << tgt) : 16'h0;
      e.ctrl  = inj ? ty : 2'b00;
      e.done  = (d != 0) && (k == s + d + 1);
      e.busy  = (d == 0) || (k <= s + d + 1);
      e.ready = !e.busy;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_target = '0; cfg_type = '0; cfg_start = '0; cfg_dur = '0;
    trig = 1'b0; abort_i = 1'b0;
    e_valid = 1'b0; e_target = '0; e_type = '0; e_start = '0; e_dur = '0;
    e_trig = 1'b0; e_abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({sbtr_en, sbtr_ctrl, busy, done, err, cfg_ready} !== 22'h0) begin
      n_miss++;
      $display("FAIL reset_outputs: got en=%h ctrl=%b busy=%b done=%b err=%b ready=%b, expected all 0",
               sbtr_en, sbtr_ctrl, busy, done, err, cfg_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || e_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_release_ready: got ready=%b busy=%b e_ready=%b, expected 1 0 1",
               cfg_ready, busy, e_ready);
    end
  endtask

  task automatic test_campaign(input string name, input int tgt, input logic [1:0] ty,
                               input int s, input int d);
    exp_t e;
    int   k;
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL %s_ready_pre: got %b, expected 1", name, cfg_ready);
    end
    cfg_target = 4'(tgt); cfg_type = ty; cfg_start = 32'(s); cfg_dur = 32'(d);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    // a different descriptor stays on the bus while ARMED and must not be taken
    cfg_target = 4'(tgt ^ 1); cfg_type = ~ty; cfg_start = 32'(s + 3); cfg_dur = 32'(d + 2);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0 || sbtr_en !== 16'h0) begin
      n_miss++;
      $display("FAIL %s_armed: got busy=%b ready=%b en=%h, expected 1 0 0000",
               name, busy, cfg_ready, sbtr_en);
    end
    repeat (2) @(posedge clk);
    #1 trig = 1'b1;
    @(posedge clk);
    #1 trig = 1'b0; cfg_valid = 1'b0;
    push_campaign(tgt, ty, s, d, s + d + 4);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_vec++;
      if ({sbtr_en, sbtr_ctrl, busy, done, cfg_ready} !== {e.en, e.ctrl, e.busy, e.done, e.ready}) begin
        n_miss++;
        $display("FAIL %s k=%0d: got en=%h ctrl=%b busy=%b done=%b ready=%b, expected en=%h ctrl=%b busy=%b done=%b ready=%b",
                 name, k, sbtr_en, sbtr_ctrl, busy, done, cfg_ready, e.en, e.ctrl, e.busy, e.done, e.ready);
      end
      k++;
    end
  endtask

  task automatic test_abort_inject();
    exp_t e;
    int   k;
    cfg_target = 4'd5; cfg_type = 2'b01; cfg_start = 32'd1; cfg_dur = 32'd0;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0; trig = 1'b1;
    @(posedge clk);
    #1 trig = 1'b0;
    push_campaign(5, 2'b01, 1, 0, 22);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_vec++;
      if ({sbtr_en, sbtr_ctrl, busy, done, cfg_ready} !== {e.en, e.ctrl, e.busy, e.done, e.ready}) begin
        n_miss++;
        $display("FAIL abort_hold k=%0d: got en=%h ctrl=%b busy=%b done=%b ready=%b, expected en=%h ctrl=%b busy=%b done=%b ready=%b",
                 k, sbtr_en, sbtr_ctrl, busy, done, cfg_ready, e.en, e.ctrl, e.busy, e.done, e.ready);
      end
      k++;
    end
    abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    repeat (3) exp_q.push_back('{en: 16'h0, ctrl: 2'b00, busy: 1'b0, done: 1'b0, ready: 1'b1});
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_vec++;
      if ({sbtr_en, sbtr_ctrl, busy, done, cfg_ready} !== {e.en, e.ctrl, e.busy, e.done, e.ready}) begin
        n_miss++;
        $display("FAIL abort_release k=%0d: got en=%h ctrl=%b busy=%b done=%b ready=%b, expected en=%h ctrl=%b busy=%b done=%b ready=%b",
                 k, sbtr_en, sbtr_ctrl, busy, done, cfg_ready, e.en, e.ctrl, e.busy, e.done, e.ready);
      end
      k++;
    end
  endtask

  task automatic test_trig_abort();
    exp_t e;
    cfg_target = 4'd2; cfg_type = 2'b01; cfg_start = 32'd0; cfg_dur = 32'd3;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0; trig = 1'b1; abort_i = 1'b1;
    @(posedge clk);
    #1 trig = 1'b0; abort_i = 1'b0;
    repeat (5) exp_q.push_back('{en: 16'h0, ctrl: 2'b00, busy: 1'b0, done: 1'b0, ready: 1'b1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_vec++;
      if ({sbtr_en, sbtr_ctrl, busy, done, cfg_ready} !== {e.en, e.ctrl, e.busy, e.done, e.ready}) begin
        n_miss++;
        $display("FAIL trig_abort: got en=%h ctrl=%b busy=%b done=%b ready=%b, expected en=%h ctrl=%b busy=%b done=%b ready=%b",
                 sbtr_en, sbtr_ctrl, busy, done, cfg_ready, e.en, e.ctrl, e.busy, e.done, e.ready);
      end
    end
    // abort while IDLE is ignored: the descriptor offered alongside it is taken
    cfg_valid = 1'b1; abort_i = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL idle_abort_ignored: got busy=%b ready=%b, expected 1 0", busy, cfg_ready);
    end
    abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
      n_miss++;
      $display("FAIL armed_abort: got busy=%b ready=%b done=%b, expected 0 1 0", busy, cfg_ready, done);
    end
  endtask

  task automatic test_reject();
    int bad[2] = '{12, 15};
    foreach (bad[i]) begin
      e_target = 4'(bad[i]); e_type = 2'b01; e_start = 4'd0; e_dur = 4'd1;
      e_valid = 1'b1;
      @(posedge clk);
      #1 e_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (e_err !== 1'b1 || e_busy !== 1'b0 || e_en !== 12'h0 || e_ready !== 1'b1) begin
        n_miss++;
        $display("FAIL reject_%0d: got err=%b busy=%b en=%h ready=%b, expected 1 0 000 1",
                 bad[i], e_err, e_busy, e_en, e_ready);
      end
      @(negedge clk);
      n_vec++;
      if (e_err !== 1'b0 || e_busy !== 1'b0 || e_en !== 12'h0) begin
        n_miss++;
        $display("FAIL reject_%0d_after: got err=%b busy=%b en=%h, expected 0 0 000",
                 bad[i], e_err, e_busy, e_en);
      end
    end
  endtask

  task automatic test_max_count();
    exp_t e;
    int   k;
    e_target = 4'd11; e_type = 2'b01; e_start = 4'd15; e_dur = 4'd15;
    e_valid = 1'b1;
    @(posedge clk);
    #1 e_valid = 1'b0; e_trig = 1'b1;
    @(posedge clk);
    #1 e_trig = 1'b0;
    push_campaign(11, 2'b01, 15, 15, 34);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_vec++;
      if ({4'h0, e_en, e_ctrl, e_busy, e_done, e_ready} !== {e.en, e.ctrl, e.busy, e.done, e.ready}) begin
        n_miss++;
        $display("FAIL max_count k=%0d: got en=%h ctrl=%b busy=%b done=%b ready=%b, expected en=%h ctrl=%b busy=%b done=%b ready=%b",
                 k, e_en, e_ctrl, e_busy, e_done, e_ready, e.en, e.ctrl, e.busy, e.done, e.ready);
      end
      k++;
    end
  endtask

  task automatic test_reset_inject();
    cfg_target = 4'd7; cfg_type = 2'b10; cfg_start = 32'd0; cfg_dur = 32'd0;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0; trig = 1'b1;
    @(posedge clk);
    #1 trig = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (sbtr_en !== 16'h0080 || sbtr_ctrl !== 2'b10) begin
      n_miss++;
      $display("FAIL rst_inject_pre: got en=%h ctrl=%b, expected 0080 10", sbtr_en, sbtr_ctrl);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (sbtr_en !== 16'h0 || sbtr_ctrl !== 2'b00 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_inject_async: got en=%h ctrl=%b busy=%b ready=%b, expected 0000 00 0 0",
               sbtr_en, sbtr_ctrl, busy, cfg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b1 || sbtr_en !== 16'h0 || done !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_inject_release: got ready=%b en=%h done=%b busy=%b, expected 1 0000 0 0",
               cfg_ready, sbtr_en, done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_campaign("basic", 3, 2'b01, 5, 4);
    test_campaign("flip", 0, 2'b10, 0, 1);
    test_campaign("top_target", 15, 2'b00, 2, 3);
    test_campaign("sa1_long", 9, 2'b01, 7, 6);
    test_abort_inject();
    test_trig_abort();
    test_reject();
    test_max_count();
    test_reset_inject();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
